// File: rtl/fpf_enc_arbiter.sv
// fpf_enc_arbiter: four requesters share one Fibonacci (Zeckendorf) encoder.
// A round-robin arbiter grants one word per cycle into a two-stage pipeline
// (s1 = raw word, s2 = encoded word) feeding a small output FIFO. Grants are
// credit-gated so every word in flight already owns a FIFO slot.
//
// Ports
//   clock      : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester valid
//   req_data   : requester i at [i*DW +: DW]
//   req_ready  : per-requester accept (one-hot or zero)
//   out_valid  : FIFO head valid
//   out_code   : 28-bit Zeckendorf codeword at the FIFO head
//   out_id     : requester index of out_code
//   out_ready  : consumer accepts the FIFO head
//   err_valid  : one-cycle pulse, rejected out-of-range word
//   err_id     : requester index of the rejected word
//
// Build option: define FPF_ARB_RANGE_CHK_EN to reject granted words >= 832040
// (F(30)) instead of encoding them.

// Greedy Zeckendorf encoder: bit k carries weight F(k+2), so codes never
// contain two adjacent ones. Valid for values below F(30) = 832040.
module FPF_encoder_28 (
  input  logic [19:0] value,
  output logic [27:0] code
);
  localparam logic [19:0] FIB [28] = '{
    20'd1, 20'd2, 20'd3, 20'd5, 20'd8, 20'd13, 20'd21, 20'd34, 20'd55,
    20'd89, 20'd144, 20'd233, 20'd377, 20'd610, 20'd987, 20'd1597,
    20'd2584, 20'd4181, 20'd6765, 20'd10946, 20'd17711, 20'd28657,
    20'd46368, 20'd75025, 20'd121393, 20'd196418, 20'd317811, 20'd514229
  };

  logic [19:0] rem;

  always_comb begin
    rem  = value;
    code = '0;
    for (int k = 27; k >= 0; k--) begin
      if (rem >= FIB[k]) begin
        code[k] = 1'b1;
        rem     = rem - FIB[k];
      end
    end
  end
endmodule

module fpf_enc_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 19,
  parameter int FIFO_D = 4
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [27:0]          out_code,
  output logic [1:0]           out_id,
  input  logic                 out_ready,
  output logic                 err_valid,
  output logic [1:0]           err_id
);
  localparam int AW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 3);

  logic [1:0]    ptr_q, ptr_d;
  logic          s1_v_q, s1_v_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [1:0]    s1_id_q, s1_id_d;
  logic          s2_v_q, s2_v_d;
  logic [27:0]   s2_code_q, s2_code_d;
  logic [1:0]    s2_id_q, s2_id_d;
  logic [27:0]   mem_code_q [FIFO_D];
  logic [27:0]   mem_code_d [FIFO_D];
  logic [1:0]    mem_id_q [FIFO_D];
  logic [1:0]    mem_id_d [FIFO_D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_id_q, err_id_d;

  logic          credit_ok, grant_any, grant_fire, word_bad, push, pop;
  logic [1:0]    grant_id, idx;
  logic [DW-1:0] grant_data;
  logic [27:0]   enc_code;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_D - 1)) ? '0 : p + AW'(1);
  endfunction

  FPF_encoder_28 u_enc (
    .value (20'(s1_data_q)),
    .code  (enc_code)
  );

  // Credit counts every word past the grant point, so a grant can never
  // produce a push into a full FIFO.
  always_comb begin
    credit_ok = (fifo_cnt_q + CW'(s1_v_q) + CW'(s2_v_q)) < CW'(FIFO_D);
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    grant_fire = credit_ok && grant_any;
    req_ready  = '0;
    if (grant_fire && rst_n) req_ready[grant_id] = 1'b1;
    grant_data = req_data[grant_id*DW +: DW];
`ifdef FPF_ARB_RANGE_CHK_EN
    word_bad = (28'(grant_data) >= 28'd832040);
`else
    word_bad = 1'b0;
`endif
  end

  always_comb begin
    ptr_d       = grant_fire ? grant_id + 2'd1 : ptr_q;
    s1_v_d      = grant_fire && !word_bad;
    s1_data_d   = s1_v_d ? grant_data : s1_data_q;
    s1_id_d     = s1_v_d ? grant_id : s1_id_q;
    err_valid_d = grant_fire && word_bad;
    err_id_d    = err_valid_d ? grant_id : err_id_q;

    s2_v_d      = s1_v_q;
    s2_code_d   = s1_v_q ? enc_code : s2_code_q;
    s2_id_d     = s1_v_q ? s1_id_q : s2_id_q;

    push        = s2_v_q;
    pop         = (fifo_cnt_q != '0) && out_ready;
    mem_code_d  = mem_code_q;
    mem_id_d    = mem_id_q;
    if (push) begin
      mem_code_d[wr_ptr_q] = s2_code_q;
      mem_id_d[wr_ptr_q]   = s2_id_q;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      s2_v_q      <= 1'b0;
      s2_code_q   <= '0;
      s2_id_q     <= '0;
      for (int k = 0; k < FIFO_D; k++) begin
        mem_code_q[k] <= '0;
        mem_id_q[k]   <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_v_q      <= s1_v_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      s2_v_q      <= s2_v_d;
      s2_code_q   <= s2_code_d;
      s2_id_q     <= s2_id_d;
      mem_code_q  <= mem_code_d;
      mem_id_q    <= mem_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign out_valid = (fifo_cnt_q != '0);
  assign out_code  = out_valid ? mem_code_q[rd_ptr_q] : '0;
  assign out_id    = out_valid ? mem_id_q[rd_ptr_q] : '0;
  assign err_valid = err_valid_q;
  assign err_id    = err_id_q;
endmodule

// File: tb/tb_fpf_enc_arbiter.sv
module tb_fpf_enc_arbiter;
`ifdef FPF_ARB_RANGE_CHK_EN
  localparam int DW = 20;
`else
  localparam int DW = 19;
`endif
  localparam int NREQ    = 4;
  localparam int FIFO_D  = 4;
  localparam int N_WORDS = 10000;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [27:0]       out_code;
  logic [1:0]        out_id;
  logic              out_ready = 1'b0;
  logic              err_valid;
  logic [1:0]        err_id;

  fpf_enc_arbiter #(.NREQ(NREQ), .DW(DW), .FIFO_D(FIFO_D)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_id    (out_id),
    .out_ready (out_ready),
    .err_valid (err_valid),
    .err_id    (err_id)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Codes for words 5,6,7,8 (weights 1,2,3,5,8,...).
  localparam logic [27:0] CODE_I5 [4] = '{28'h8, 28'h9, 28'hA, 28'h10};

  function automatic int fib_decode(input logic [27:0] c);
    int a = 1, b = 2, s = 0, t;
    for (int k = 0; k < 28; k++) begin
      if (c[k]) s += a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int i, input int v);
    req_data[i*DW +: DW] = DW'(v);
  endtask

  task automatic reset_dut;
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  typedef struct { int word; logic [1:0] id; } exp_t;
  exp_t  sb_q [$];
  bit    mon_en = 0;
  int    accepted = 0, delivered = 0;
  bit    held_v = 0;
  logic [27:0] held_code;
  logic [1:0]  held_id;

  always @(negedge clock) begin
    if (mon_en) begin
      exp_t e;
      chk("rnd_onehot", 32'($onehot0(req_ready)), 1);
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_code", out_code, held_code);
        chk("hold_id", out_id, held_id);
      end
      held_v    = out_valid && !out_ready;
      held_code = out_code;
      held_id   = out_id;
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          e.word = int'(req_data[k*DW +: DW]);
          e.id   = 2'(k);
          sb_q.push_back(e);
          accepted++;
        end
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("rnd_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("rnd_id", out_id, e.id);
          chk("rnd_value", fib_decode(out_code), e.word);
          chk("rnd_zeck", out_code & (out_code >> 1), 0);
          delivered++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state, with a request pending during reset.
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) set_data(i, 0);
    tick; tick;
    @(negedge clock);
    chk("rst_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_id", err_id, 0);
    tick;
    rst_n = 1'b1;

    // Single request, latency T+3.
    @(negedge clock); chk("t1_ready", req_ready, 4'b0100);
    tick; req_valid = '0;
    @(negedge clock); chk("t1_valid_t1", out_valid, 0); chk("t1_err_t1", err_valid, 0);
    tick;
    @(negedge clock); chk("t1_valid_t2", out_valid, 0);
    tick; out_ready = 1'b1;
    @(negedge clock);
    chk("t1_valid_t3", out_valid, 1);
    chk("t1_code", out_code, 0);
    chk("t1_id", out_id, 2);
    tick;
    @(negedge clock); chk("t1_valid_t4", out_valid, 0);

    // Full throughput, round-robin order, no bubbles.
    reset_dut;
    req_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, i + 5);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk("t2_ready", req_ready, (c < 8) ? (32'd1 << (c % 4)) : 0);
      if (c >= 3 && c < 11) begin
        chk("t2_valid", out_valid, 1);
        chk("t2_id", out_id, (c - 3) % 4);
        chk("t2_code", out_code, CODE_I5[(c - 3) % 4]);
      end else chk("t2_valid_idle", out_valid, 0);
      tick;
      if (c == 7) req_valid = '0;
    end

    // Backpressure: exactly FIFO_D accepts, stable head, ordered drain.
    reset_dut;
    req_valid = 4'hF; out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("t3_ready", req_ready, (c < 4) ? (32'd1 << c) : 0);
      if (c >= 3) begin
        chk("t3_valid", out_valid, 1);
        chk("t3_code_hold", out_code, CODE_I5[0]);
        chk("t3_id_hold", out_id, 0);
      end
      tick;
    end
    req_valid = '0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t3_drain_valid", out_valid, 1);
      chk("t3_drain_id", out_id, k);
      chk("t3_drain_code", out_code, CODE_I5[k]);
      tick;
    end
    @(negedge clock); chk("t3_empty", out_valid, 0);

    // Mid-stream reset with three words in flight.
    reset_dut;
    req_valid = 4'hF; out_ready = 1'b0;
    tick; tick; tick;
    chk("t4_pre_valid", out_valid, 1);
    #1;
    rst_n = 1'b0; req_valid = '0;
    #1;
    chk("t4_async_valid", out_valid, 0);
    chk("t4_async_code", out_code, 0);
    chk("t4_async_id", out_id, 0);
    chk("t4_async_ready", req_ready, 0);
    tick;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); chk("t4_no_stale", out_valid, 0);
      tick;
    end
    req_valid = 4'hF;
    @(negedge clock); chk("t4_ptr0", req_ready, 4'b0001);
    tick; req_valid = '0;
    repeat (5) tick;

`ifdef FPF_ARB_RANGE_CHK_EN
    // Range check: reject F(30), advance pointer, then accept F(30)-1.
    reset_dut;
    out_ready = 1'b1;
    set_data(1, 832040); set_data(2, 7);
    req_valid = 4'b0010;
    @(negedge clock); chk("t5_rej_ready", req_ready, 4'b0010); chk("t5_err_t0", err_valid, 0);
    tick; req_valid = '0;
    @(negedge clock);
    chk("t5_err_t1", err_valid, 1);
    chk("t5_err_id", err_id, 1);
    chk("t5_rej_nov1", out_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      @(negedge clock);
      chk("t5_err_pulse", err_valid, 0);
      chk("t5_rej_nov", out_valid, 0);
    end
    tick;
    set_data(1, 832039);
    req_valid = 4'b0110;
    @(negedge clock); chk("t5_ptr_adv", req_ready, 4'b0100);
    tick; req_valid = 4'b0010;
    @(negedge clock); chk("t5_ok_ready", req_ready, 4'b0010);
    tick; req_valid = '0;
    tick;
    @(negedge clock);
    chk("t5_v2", out_valid, 1); chk("t5_id2", out_id, 2); chk("t5_code2", out_code, 28'hA);
    tick;
    @(negedge clock);
    chk("t5_v1", out_valid, 1); chk("t5_id1", out_id, 1); chk("t5_code1", out_code, 28'hAAAAAAA);
    chk("t5_err_none", err_valid, 0);
    repeat (3) tick;
`endif

    // Random traffic against the scoreboard.
    reset_dut;
    mon_en = 1; cyc = 0;
    while (accepted < N_WORDS && cyc < 60000) begin
      req_valid = 4'($urandom_range(0, 15));
`ifdef FPF_ARB_RANGE_CHK_EN
      for (int i = 0; i < 4; i++) set_data(i, int'($urandom_range(0, 832039)));
`else
      for (int i = 0; i < 4; i++) set_data(i, int'($urandom_range(0, (1 << DW) - 1)));
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      tick;
      cyc++;
    end
    req_valid = '0; out_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 100) begin tick; cyc++; end
    repeat (5) tick;
    mon_en = 0;
    chk("rnd_accepted", accepted, N_WORDS);
    chk("rnd_delivered", delivered, N_WORDS);
    chk("rnd_left", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
